// File: rtl/edge_zone_pkg.sv
// Shared types and constants for the edge zone counter.
package edge_zone_pkg;

    // Default active frame size. A 640x480 frame has at most 307200 pixels,
    // which fits in a 19-bit count without wrapping.
    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;
    localparam int COUNT_W   = 19;
    localparam int COORD_W   = 10;

    // Frame FSM: wait for pixel (0,0), accumulate, then a one-cycle latch.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Inclusive range test. A zone whose min exceeds its max never matches.
    function automatic logic in_range(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/edge_zone_counter_if.sv
// Pixel bus: one Sobel result with its coordinate and valid flag.
interface edge_zone_counter_if;
    logic                            de;
    logic [edge_zone_pkg::COORD_W-1:0] x;
    logic [edge_zone_pkg::COORD_W-1:0] y;
    logic                            edge_bit;

    modport master (output de, x, y, edge_bit);
    modport slave  (input  de, x, y, edge_bit);
endinterface

// File: rtl/zone_accum.sv
// One rectangular zone: bound compare plus edge-pixel accumulator.
module zone_accum
    import edge_zone_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    edge_zone_counter_if.slave pix,
    input  logic               count_en,   // pixel is part of the current frame
    input  logic               clear,      // drop the running count
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] y_max,
    output logic [COUNT_W-1:0] acc
);

    logic [COUNT_W-1:0] acc_q;
    logic [COUNT_W-1:0] acc_d;
    logic               hit_px;

    // Count an edge pixel that lies inside this zone's inclusive bounds.
    always_comb begin
        hit_px = count_en && pix.de && pix.edge_bit &&
                 in_range(pix.x, x_min, x_max) &&
                 in_range(pix.y, y_min, y_max);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (hit_px) begin
            acc_d = acc_q + 1'b1;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/edge_zone_counter.sv
// Counts Sobel edge pixels per rectangular zone over a frame and latches
// per-zone counts and hit flags at the end of each complete frame.
//
// Result handshake: result_valid rises when a frame's results are latched
// and stays high until result_ack is sampled high; result_ack while
// result_valid is low has no effect. A new latch while result_valid is still
// high and not acked in that same cycle overwrites the results and sets the
// sticky overrun flag, which only reset clears.
//
// Timing: a pixel launched on edge n is counted at edge n+1 (state LATCH);
// results are visible after edge n+2.
module edge_zone_counter
    import edge_zone_pkg::*;
#(
    parameter int H_ACT    = H_ACT_DEF,
    parameter int V_ACT    = V_ACT_DEF,
    parameter int ZONE_NUM = 4,
    parameter int HIT_TH   = 200
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              DE,
    input  logic [COORD_W-1:0]                x_pixel,
    input  logic [COORD_W-1:0]                y_pixel,
    input  logic                              edge_in,
    input  logic [ZONE_NUM-1:0][COORD_W-1:0]  zone_x_min,
    input  logic [ZONE_NUM-1:0][COORD_W-1:0]  zone_x_max,
    input  logic [ZONE_NUM-1:0][COORD_W-1:0]  zone_y_min,
    input  logic [ZONE_NUM-1:0][COORD_W-1:0]  zone_y_max,
    output logic [ZONE_NUM-1:0][COUNT_W-1:0]  zone_count,
    output logic [ZONE_NUM-1:0]               zone_hit,
    output logic                              result_valid,
    input  logic                              result_ack,
    output logic                              overrun,
    output logic [1:0]                        state_dbg
);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACT - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACT - 1);
    localparam logic [COUNT_W-1:0] HIT_TH_C = COUNT_W'(HIT_TH);

    state_e                             state_q;
    state_e                             state_d;
    logic [ZONE_NUM-1:0][COUNT_W-1:0]   zone_count_q;
    logic [ZONE_NUM-1:0][COUNT_W-1:0]   zone_count_d;
    logic [ZONE_NUM-1:0]                zone_hit_q;
    logic [ZONE_NUM-1:0]                zone_hit_d;
    logic                               result_valid_q;
    logic                               result_valid_d;
    logic                               overrun_q;
    logic                               overrun_d;

    logic [ZONE_NUM-1:0][COUNT_W-1:0]   acc_all;
    logic                               count_en;
    logic                               acc_clear;
    logic                               in_frame;
    logic                               is_first;
    logic                               is_last;

    edge_zone_counter_if pix_bus ();

    assign pix_bus.de       = DE;
    assign pix_bus.x        = x_pixel;
    assign pix_bus.y        = y_pixel;
    assign pix_bus.edge_bit = edge_in;

    assign in_frame = (x_pixel <= X_LAST) && (y_pixel <= Y_LAST);
    assign is_first = (x_pixel == '0) && (y_pixel == '0);
    assign is_last  = (x_pixel == X_LAST) && (y_pixel == Y_LAST);

    // Frame sequencing: start on (0,0), count valid in-window pixels,
    // abort on en low, latch after the last pixel.
    always_comb begin
        state_d   = state_q;
        count_en  = 1'b0;
        acc_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && DE && is_first) begin
                    count_en = 1'b1;
                    state_d  = is_last ? ST_LATCH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!en) begin
                    acc_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (DE && in_frame) begin
                    count_en = 1'b1;
                    if (is_last) begin
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                acc_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result registers and handshake flags.
    always_comb begin
        zone_count_d   = zone_count_q;
        zone_hit_d     = zone_hit_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        if (result_valid_q && result_ack) begin
            result_valid_d = 1'b0;
        end
        if (state_q == ST_LATCH) begin
            zone_count_d   = acc_all;
            result_valid_d = 1'b1;
            for (int z = 0; z < ZONE_NUM; z++) begin
                zone_hit_d[z] = (acc_all[z] >= HIT_TH_C);
            end
            if (result_valid_q && !result_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            zone_count_q   <= '0;
            zone_hit_q     <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            zone_count_q   <= zone_count_d;
            zone_hit_q     <= zone_hit_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    for (genvar g = 0; g < ZONE_NUM; g++) begin : g_zone
        zone_accum u_zone_accum (
            .clk      (clk),
            .reset    (reset),
            .pix      (pix_bus),
            .count_en (count_en),
            .clear    (acc_clear),
            .x_min    (zone_x_min[g]),
            .x_max    (zone_x_max[g]),
            .y_min    (zone_y_min[g]),
            .y_max    (zone_y_max[g]),
            .acc      (acc_all[g])
        );
    end

    assign zone_count   = zone_count_q;
    assign zone_hit     = zone_hit_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;
    assign state_dbg    = state_q;

endmodule
